// File: rtl/bitstream_reader_if.sv
// Producer/consumer bundle for bitstream_reader: byte-lane writes, windowed pops and status.
interface bitstream_reader_if #(
   parameter int BITSTREAM_WIDTH = 8,
   parameter int FIFO_ADDR_WIDTH = 4,
   parameter int WINDOW_WIDTH    = 16
);
   logic [BITSTREAM_WIDTH-1:0] in_bit_1;
   logic [BITSTREAM_WIDTH-1:0] in_bit_2;
   logic [BITSTREAM_WIDTH-1:0] in_bit_3;
   logic [2:0]                 in_flag;
   logic                       in_last;
   logic                       in_ready;
   logic                       rd_req;
   logic [1:0]                 rd_bytes;
   logic [WINDOW_WIDTH-1:0]    out_window;
   logic                       out_valid;
   logic [FIFO_ADDR_WIDTH:0]   out_avail;
   logic                       out_done;
   logic                       out_error;
   logic [31:0]                out_byte_count;
   logic                       start;

   modport master (
      output in_bit_1, in_bit_2, in_bit_3, in_flag, in_last, rd_req, rd_bytes, start,
      input  in_ready, out_window, out_valid, out_avail, out_done, out_error, out_byte_count
   );

   modport slave (
      input  in_bit_1, in_bit_2, in_bit_3, in_flag, in_last, rd_req, rd_bytes, start,
      output in_ready, out_window, out_valid, out_avail, out_done, out_error, out_byte_count
   );
endinterface

// File: rtl/bitstream_reader.sv
// Byte circular buffer turning up-to-3-byte writes into a 2-byte look-ahead window with pops.
// Optional popped-byte counter enabled by defining BITSTREAM_READER_STATS_EN.
module bitstream_reader #(
   parameter int BITSTREAM_WIDTH = 8,
   parameter int FIFO_ADDR_WIDTH = 4,
   parameter int WINDOW_WIDTH    = 16
) (
   input  logic              clk,
   input  logic              reset,
   bitstream_reader_if.slave bus
);
   localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
   localparam int CW    = FIFO_ADDR_WIDTH + 1;
   localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE = 1;
   localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_TWO = 2;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [BITSTREAM_WIDTH-1:0] r_mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
   logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CW-1:0]              r_count;
   logic                       r_error;

   logic [CW-1:0]              w_free;
   logic [CW-1:0]              w_flag_n;
   logic [CW-1:0]              w_req_n;
   logic [CW-1:0]              w_pop_n;
   logic [CW-1:0]              w_count_next;
   logic                       w_wr_phase;
   logic                       w_flag_legal;
   logic                       w_flag_bad;
   logic                       w_overflow;
   logic                       w_wr_en;
   logic                       w_last_ok;
   logic [BITSTREAM_WIDTH-1:0] w_byte_0;
   logic [BITSTREAM_WIDTH-1:0] w_byte_1;

   // Free space is judged before any same-cycle pop, so a full buffer rejects even when draining.
   always_comb begin
      w_free       = CW'(DEPTH) - r_count;
      w_flag_n     = CW'(bus.in_flag);
      w_wr_phase   = (r_state == S_IDLE) || (r_state == S_STREAM);
      w_flag_legal = (bus.in_flag != 3'd0) && (bus.in_flag <= 3'd3);
      w_flag_bad   = w_wr_phase && (bus.in_flag > 3'd3);
      w_overflow   = w_wr_phase && w_flag_legal && (w_flag_n > w_free);
      w_wr_en      = w_wr_phase && w_flag_legal && !w_overflow;
      w_last_ok    = bus.in_last && (w_wr_en || ((r_state == S_STREAM) && (bus.in_flag == 3'd0)));
      w_req_n      = (bus.rd_req && (bus.rd_bytes != 2'd3)) ? CW'(bus.rd_bytes) : '0;
      w_pop_n      = '0;
      case (r_state)
         S_STREAM: if (r_count >= w_req_n) w_pop_n = w_req_n;
         S_DRAIN:  w_pop_n = (w_req_n < r_count) ? w_req_n : r_count;
         default:  w_pop_n = '0;
      endcase
      w_count_next = r_count + (w_wr_en ? w_flag_n : '0) - w_pop_n;

      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_last_ok)    w_state_next = S_DRAIN;
            else if (w_wr_en) w_state_next = S_STREAM;
         end
         S_STREAM: if (w_last_ok) w_state_next = S_DRAIN;
         S_DRAIN:  if (w_count_next == '0) w_state_next = S_DONE;
         default:  w_state_next = r_state;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_error  <= 1'b0;
      end else if (bus.start) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_error  <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_wr_ptr <= r_wr_ptr + (w_wr_en ? w_flag_n[FIFO_ADDR_WIDTH-1:0] : '0);
         r_rd_ptr <= r_rd_ptr + w_pop_n[FIFO_ADDR_WIDTH-1:0];
         r_count  <= w_count_next;
         r_error  <= r_error | w_flag_bad | w_overflow;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr_en && !bus.start) begin
         r_mem[r_wr_ptr] <= bus.in_bit_1;
         if (bus.in_flag >= 3'd2) r_mem[r_wr_ptr + PTR_ONE] <= bus.in_bit_2;
         if (bus.in_flag == 3'd3) r_mem[r_wr_ptr + PTR_TWO] <= bus.in_bit_3;
      end
   end

   // Positions past the stored count read as zero padding rather than stale buffer bytes.
   assign w_byte_0 = (r_count >= CW'(1)) ? r_mem[r_rd_ptr] : '0;
   assign w_byte_1 = (r_count >= CW'(2)) ? r_mem[r_rd_ptr + PTR_ONE] : '0;

   assign bus.out_window = WINDOW_WIDTH'({w_byte_0, w_byte_1});
   assign bus.out_valid  = (r_count >= CW'(2)) || ((r_state == S_DRAIN) && (r_count != '0));
   assign bus.out_avail  = r_count;
   assign bus.out_done   = (r_state == S_DONE);
   assign bus.out_error  = r_error;
   assign bus.in_ready   = (w_free >= CW'(3)) && w_wr_phase;

`ifdef BITSTREAM_READER_STATS_EN
   logic [31:0] r_byte_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         r_byte_count <= '0;
      else if (bus.start) r_byte_count <= '0;
      else                r_byte_count <= r_byte_count + 32'(w_pop_n);
   end

   assign bus.out_byte_count = r_byte_count;
`else
   assign bus.out_byte_count = '0;
`endif

endmodule

// File: tb/tb_bitstream_reader.sv
// Directed and randomized bench for bitstream_reader against a queue-based byte-stream model.
module tb_bitstream_reader;
   localparam int BW    = 8;
   localparam int FAW   = 4;
   localparam int WW    = 16;
   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   bitstream_reader_if #(.BITSTREAM_WIDTH(BW), .FIFO_ADDR_WIDTH(FAW), .WINDOW_WIDTH(WW)) bus ();

   bitstream_reader #(.BITSTREAM_WIDTH(BW), .FIFO_ADDR_WIDTH(FAW), .WINDOW_WIDTH(WW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model: the unread bytes in stream order, a stream phase, sticky error and popped total.
   logic [7:0]  q[$];
   int          phase;   // 0 idle, 1 streaming, 2 draining, 3 done
   bit          m_err;
   logic [31:0] m_total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [15:0] ew;
      logic [31:0] ecnt;
      ew[15:8] = (q.size() >= 1) ? q[0] : 8'h00;
      ew[7:0]  = (q.size() >= 2) ? q[1] : 8'h00;
`ifdef BITSTREAM_READER_STATS_EN
      ecnt = m_total;
`else
      ecnt = 32'd0;
`endif
      chk({tag, ".window"}, 32'(bus.out_window), 32'(ew));
      chk({tag, ".valid"},  32'(bus.out_valid), 32'((q.size() >= 2) || (phase == 2 && q.size() >= 1)));
      chk({tag, ".avail"},  32'(bus.out_avail), 32'(q.size()));
      chk({tag, ".done"},   32'(bus.out_done),  32'(phase == 3));
      chk({tag, ".error"},  32'(bus.out_error), 32'(m_err));
      chk({tag, ".ready"},  32'(bus.in_ready),  32'(((DEPTH - q.size()) >= 3) && (phase <= 1)));
      chk({tag, ".bytes"},  bus.out_byte_count, ecnt);
   endtask

   task automatic model_clear();
      q.delete();
      phase   = 0;
      m_err   = 1'b0;
      m_total = '0;
   endtask

   // One clock: present inputs, advance the model by the stream rules, then compare after the edge.
   task automatic step(input string tag, input int flag, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input bit last, input bit rq, input int rb, input bit st);
      int pre, take, n;
      bit wphase, wr_ok, last_ok;
      bus.in_flag  = 3'(flag);
      bus.in_bit_1 = b1;
      bus.in_bit_2 = b2;
      bus.in_bit_3 = b3;
      bus.in_last  = last;
      bus.rd_req   = rq;
      bus.rd_bytes = 2'(rb);
      bus.start    = st;
      pre = q.size();
      if (st) begin
         model_clear();
      end else if (phase != 3) begin
         wphase = (phase <= 1);
         wr_ok  = 1'b0;
         if (wphase) begin
            if (flag > 3) m_err = 1'b1;
            else if (flag > 0) begin
               if (flag > DEPTH - pre) m_err = 1'b1;
               else wr_ok = 1'b1;
            end
         end
         n    = rq ? rb : 0;
         take = 0;
         if (phase == 1)      take = (pre >= n) ? n : 0;
         else if (phase == 2) take = (n < pre) ? n : pre;
         repeat (take) void'(q.pop_front());
         m_total = m_total + 32'(take);
         if (wr_ok) begin
            q.push_back(b1);
            if (flag >= 2) q.push_back(b2);
            if (flag == 3) q.push_back(b3);
         end
         last_ok = last && (wr_ok || (phase == 1 && flag == 0));
         if (phase == 2 && q.size() == 0) phase = 3;
         else if (wphase && last_ok)      phase = 2;
         else if (phase == 0 && wr_ok)    phase = 1;
      end
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic idle_inputs();
      bus.in_flag  = 3'd0;
      bus.in_bit_1 = 8'h00;
      bus.in_bit_2 = 8'h00;
      bus.in_bit_3 = 8'h00;
      bus.in_last  = 1'b0;
      bus.rd_req   = 1'b0;
      bus.rd_bytes = 2'd0;
      bus.start    = 1'b0;
   endtask

   initial begin
      int nxt_w, nxt_r, f, rb;
      bit rq;
      logic [31:0] exp_stat;

      idle_inputs();
      model_clear();

      // Reset values while reset is held low
      #12;
      check_model("reset");
      chk("reset.window_const", 32'(bus.out_window), 32'h0000);
      chk("reset.ready_const", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Basic write then pop
      step("basic_wr", 3, 8'hAA, 8'hBB, 8'hCC, 0, 0, 0, 0);
      chk("basic.window_AABB", 32'(bus.out_window), 32'h0000AABB);
      chk("basic.avail_3", 32'(bus.out_avail), 32'd3);
      step("basic_pop", 0, 8'h00, 8'h00, 8'h00, 0, 1, 2, 0);
      chk("basic.window_CC00", 32'(bus.out_window), 32'h0000CC00);
      chk("basic.valid_0", 32'(bus.out_valid), 32'd0);

      // Overflow: 15 bytes then a 2-byte write
      step("ovf_start", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++)
         step("ovf_fill", 3, 8'(3*i), 8'(3*i+1), 8'(3*i+2), 0, 0, 0, 0);
      step("ovf_write", 2, 8'hEE, 8'hFF, 8'h00, 0, 0, 0, 0);
      chk("ovf.error_1", 32'(bus.out_error), 32'd1);
      chk("ovf.avail_15", 32'(bus.out_avail), 32'd15);
      chk("ovf.ready_0", 32'(bus.in_ready), 32'd0);

      // Wrap-around: 40 bytes, 3 in / 2 out
      step("wrap_start", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
      nxt_w = 0;
      nxt_r = 0;
      for (int k = 0; k < 200 && nxt_r < 40; k++) begin
         f = 0;
         if (nxt_w < 40 && (DEPTH - q.size()) >= 3) f = (40 - nxt_w >= 3) ? 3 : 40 - nxt_w;
         rq = (q.size() >= 1);
         rb = (q.size() >= 2) ? 2 : 1;
         if (rq) begin
            chk("wrap.hi", 32'(bus.out_window[15:8]), 32'(nxt_r));
            if (rb == 2) chk("wrap.lo", 32'(bus.out_window[7:0]), 32'(nxt_r + 1));
            nxt_r += rb;
         end
         step("wrap", f, 8'(nxt_w), 8'(nxt_w + 1), 8'(nxt_w + 2), 0, rq, rb, 0);
         nxt_w += f;
      end
      chk("wrap.empty", 32'(bus.out_avail), 32'd0);

      // End of stream with drain to done
      step("eos_start", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
      step("eos_wr", 3, 8'h11, 8'h22, 8'h33, 1, 0, 0, 0);
      step("eos_pop1", 0, 8'h00, 8'h00, 8'h00, 0, 1, 2, 0);
      chk("eos.window_3300", 32'(bus.out_window), 32'h00003300);
      chk("eos.valid_1", 32'(bus.out_valid), 32'd1);
      step("eos_pop2", 0, 8'h00, 8'h00, 8'h00, 0, 1, 2, 0);
      chk("eos.done_1", 32'(bus.out_done), 32'd1);
      step("eos_ignored", 3, 8'h01, 8'h02, 8'h03, 0, 1, 1, 0);
      chk("eos.done_holds_avail", 32'(bus.out_avail), 32'd0);

      // in_last with no data while streaming
      step("last0_start", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
      step("last0_wr", 2, 8'h5A, 8'hA5, 8'h00, 0, 0, 0, 0);
      step("last0_pop", 0, 8'h00, 8'h00, 8'h00, 0, 1, 2, 0);
      step("last0_last", 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
      chk("last0.not_done_yet", 32'(bus.out_done), 32'd0);
      step("last0_done", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
      chk("last0.done_1", 32'(bus.out_done), 32'd1);

      // Illegal flag value
      step("bad_start", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
      step("bad_flag", 6, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0);
      chk("bad.error_1", 32'(bus.out_error), 32'd1);
      chk("bad.avail_0", 32'(bus.out_avail), 32'd0);

      // Reset mid-operation with 7 bytes buffered
      step("rst_start", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
      step("rst_wr1", 3, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0);
      step("rst_wr2", 3, 8'h04, 8'h05, 8'h06, 0, 0, 0, 0);
      step("rst_wr3", 1, 8'h07, 8'h00, 8'h00, 0, 0, 0, 0);
      idle_inputs();
      reset = 1'b0;
      model_clear();
      #2;
      check_model("rst_mid");
      chk("rst_mid.avail_0", 32'(bus.out_avail), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      step("rst_wr44", 1, 8'h44, 8'h00, 8'h00, 0, 0, 0, 0);
      chk("rst.window_4400", 32'(bus.out_window), 32'h00004400);

      // Stats counter: 10 bytes popped
      step("stat_start", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
      step("stat_wr", 3, 8'h21, 8'h22, 8'h23, 0, 0, 0, 0);
      step("stat_wr", 3, 8'h24, 8'h25, 8'h26, 0, 0, 0, 0);
      step("stat_wr", 3, 8'h27, 8'h28, 8'h29, 0, 0, 0, 0);
      step("stat_wr", 1, 8'h2A, 8'h00, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         step("stat_pop", 0, 8'h00, 8'h00, 8'h00, 0, 1, 2, 0);
`ifdef BITSTREAM_READER_STATS_EN
      exp_stat = 32'd10;
`else
      exp_stat = 32'd0;
`endif
      chk("stat.byte_count", bus.out_byte_count, exp_stat);

      // Randomized traffic against the model
      step("rnd_start", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
      for (int i = 0; i < 600; i++) begin
         int  fl;
         bit  lst, st;
         fl  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
         lst = ($urandom_range(0, 29) == 0);
         st  = ($urandom_range(0, 59) == 0) || (phase == 3 && $urandom_range(0, 3) == 0);
         step("rnd", fl, 8'($urandom), 8'($urandom), 8'($urandom), lst,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), st);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bitstream_reader.md
BITSTREAM_READER -- requirements
Module: bitstream_reader

Interface
REQ-001 SHALL have parameter BITSTREAM_WIDTH, default 8, meaning the byte width of each bitstream lane.
REQ-002 SHALL have parameter FIFO_ADDR_WIDTH, default 4, meaning log2 of the byte-buffer depth (16 entries).
REQ-003 SHALL have parameter WINDOW_WIDTH, default 16, meaning the width of the output window (2 bytes).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports in_bit_1, in_bit_2, in_bit_3, input, 8 bits each: incoming bytes in stream order, with lane 1 first.
REQ-007 SHALL have port in_flag, input, 3 bits: number of valid lanes this cycle (0-3); values 4-7 are illegal.
REQ-008 SHALL have port in_last, input, 1 bit: the current write carries the final bytes of the stream.
REQ-009 SHALL have port in_ready, output, 1 bit: the buffer can accept a 3-byte write.
REQ-010 SHALL have port rd_req, input, 1 bit: the consumer pops bytes this cycle.
REQ-011 SHALL have port rd_bytes, input, 2 bits: number of bytes to pop (1 or 2); value 0 is a no-op.
REQ-012 SHALL have port out_window, output, 16 bits: the next two unread bytes, oldest in [15:8].
REQ-013 SHALL have port out_valid, output, 1 bit: out_window holds real or legally padded data.
REQ-014 SHALL have port out_avail, output, FIFO_ADDR_WIDTH+1 bits: current byte count.
REQ-015 SHALL have port out_done, output, 1 bit: the stream has been fully consumed.
REQ-016 SHALL have port out_error, output, 1 bit: sticky error, set by overflow or by an illegal in_flag.
REQ-017 SHALL have port out_byte_count, output, 32 bits: total bytes popped (see Configuration).
REQ-018 SHALL have port start, input, 1 bit: synchronous restart to IDLE that clears the buffer, the error and the counter.

Function
REQ-019 SHALL implement a circular buffer of 2^FIFO_ADDR_WIDTH bytes with wrapping write/read pointers, where count = writes - pops.
REQ-020 SHALL accept a write when in_flag is between 1 and 3 and free space >= in_flag, storing lanes 1..in_flag in order at the write pointer.
REQ-021 SHALL drop the whole write and set out_error when in_flag exceeds free space, with free space computed before any same-cycle pop.
REQ-022 SHALL ignore the write and set out_error when in_flag is 4-7.
REQ-023 SHALL drive in_ready = (free >= 3) AND state is IDLE or STREAM.
REQ-024 SHALL form out_window combinationally from the buffer at rd_ptr and rd_ptr+1, substituting 0x00 for any position at or beyond count.
REQ-025 SHALL give a written byte a latency of one cycle: it is visible on out_window in the cycle after the write edge, including wrap-around.
REQ-026 SHALL drive out_valid = (count >= 2), or (state is DRAIN AND count >= 1).
REQ-027 SHALL, in STREAM, pop rd_bytes only if count >= rd_bytes; otherwise the pop is stalled (no state change, no error).
REQ-028 SHALL, in DRAIN, pop min(rd_bytes, count).
REQ-029 SHALL apply a simultaneous write and pop in the same cycle, giving count = count + in_flag - popped.
REQ-030 SHALL implement a state machine with states IDLE, STREAM, DRAIN and DONE, with the following transitions:
- IDLE -> STREAM on the first accepted write.
- IDLE or STREAM -> DRAIN on an accepted write with in_last=1.
- DRAIN -> DONE when count reaches 0.
- DONE holds until start.
REQ-031 SHALL enter DRAIN with an empty buffer when in_last is accepted alongside in_flag=0 in STREAM; count is 0, so the block goes to DONE on the next cycle.
REQ-032 SHALL drive out_done = (state == DONE), and SHALL ignore writes and pops in DONE.
REQ-033 SHALL give start priority over a same-cycle write or pop.

Reset
REQ-034 SHALL, while reset=0, asynchronously force the following values:
- state IDLE, pointers 0, count 0, buffer contents 0.
- out_window 0x0000, out_valid 0, out_avail 0, out_done 0, out_error 0, out_byte_count 0, in_ready 1.
REQ-035 SHALL make reset asserted mid-stream discard all buffered bytes, with no partial pop or write completing on that edge.

Configuration
REQ-036 SHALL, with macro BITSTREAM_READER_STATS_EN defined, increment out_byte_count by the bytes popped each cycle, wrapping at 2^32.
REQ-037 SHALL, without BITSTREAM_READER_STATS_EN, tie out_byte_count to 0 and instantiate no counter logic.

Verification
REQ-038 SHALL cover a basic write and pop: write 3 bytes AA,BB,CC, then on the next cycle out_window=AABB and out_avail=3; pop 2, then out_window=CC00 and out_valid=0 (STREAM).
REQ-039 SHALL cover overflow: fill 15 bytes, then write in_flag=2, giving out_error=1, out_avail=15 and in_ready=0.
REQ-040 SHALL cover wrap-around: push and pop 40 bytes 00..27 in a 3-in/2-out pattern, with every out_window pair in order across the pointer wrap.
REQ-041 SHALL cover the end of stream: write 11,22,33 with in_last; pop 2 then pop 2, giving out_window=3300 with out_valid=1, then out_done=1 on the following cycle.
REQ-042 SHALL cover reset mid-operation: with 7 bytes buffered, pulse reset low, giving all outputs at their reset values and a following write of 44 showing out_window=4400.
REQ-043 SHALL cover the stats counter: with BITSTREAM_READER_STATS_EN, 10 bytes popped gives out_byte_count=10; without the macro, out_byte_count=0.
